// File: rtl/stat_update_arbiter.sv
// Arbitrates user actions and timed decay requests onto a single {stat, direction} update port.
// Optional heal lockout is enabled by defining HEAL_LOCKOUT_EN.
module stat_update_arbiter #(
  parameter int TICK_DIV       = 50000000,
  parameter int FOOD_PERIOD_S  = 30,
  parameter int SLEEP_PERIOD_S = 31,
  parameter int FUN_PERIOD_S   = 23,
  parameter int HAPPY_PERIOD_S = 24,
  parameter int HEAL_LOCKOUT_S = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       act_heal,
  input  logic       act_feed,
  input  logic       act_rest,
  input  logic       act_play,
  input  logic       pause,
  output logic       upd_valid,
  input  logic       upd_ready,
  output logic [2:0] upd_stat,
  output logic       upd_up,
  output logic [7:0] pend,
  output logic       sec_tick,
  output logic       drop_err
);

  localparam int PW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int MAXP_A = (FOOD_PERIOD_S > SLEEP_PERIOD_S) ? FOOD_PERIOD_S : SLEEP_PERIOD_S;
  localparam int MAXP_B = (FUN_PERIOD_S > HAPPY_PERIOD_S) ? FUN_PERIOD_S : HAPPY_PERIOD_S;
  localparam int MAXP   = (MAXP_A > MAXP_B) ? MAXP_A : MAXP_B;
  localparam int TW     = $clog2(MAXP + 1);
  localparam int PER [4] = '{FOOD_PERIOD_S, SLEEP_PERIOD_S, FUN_PERIOD_S, HAPPY_PERIOD_S};

  typedef enum logic {IDLE, OFFER} state_t;

  state_t          state;
  logic [PW-1:0]   pre_cnt;
  logic [TW-1:0]   tmr [4];
  logic [3:0]      expire;
  logic [7:0]      set_req;
  logic [7:0]      clr;
  logic [2:0]      sel;
  logic [2:0]      win;
  logic [1:0]      last;
  logic [1:0]      cand;
  logic            found;
  logic            heal_ok;

  // Pend index -> {stat, up}; indices 7..4 are user actions, 3..0 are decays of stat k.
  function automatic logic [3:0] cmd_of(input logic [2:0] idx);
    case (idx)
      3'd7:    cmd_of = {3'd4, 1'b1};
      3'd6:    cmd_of = {3'd0, 1'b1};
      3'd5:    cmd_of = {3'd1, 1'b1};
      3'd4:    cmd_of = {3'd2, 1'b1};
      default: cmd_of = {1'b0, idx[1:0], 1'b0};
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!rst)
      pre_cnt <= '0;
    else if (!pause)
      pre_cnt <= (pre_cnt == PW'(TICK_DIV - 1)) ? '0 : pre_cnt + PW'(1);
  end

  assign sec_tick = !pause && (pre_cnt == PW'(TICK_DIV - 1));

  always_comb begin
    expire = '0;
    for (int k = 0; k < 4; k++)
      expire[k] = sec_tick && (tmr[k] == TW'(PER[k] - 1));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 4; k++) tmr[k] <= '0;
    end else if (sec_tick) begin
      for (int k = 0; k < 4; k++) tmr[k] <= expire[k] ? '0 : tmr[k] + TW'(1);
    end
  end

`ifdef HEAL_LOCKOUT_EN
  localparam int LW = (HEAL_LOCKOUT_S > 0) ? $clog2(HEAL_LOCKOUT_S + 1) : 1;
  logic [LW-1:0] lock_cnt;

  always_ff @(posedge clk) begin
    if (!rst)
      lock_cnt <= '0;
    else if (upd_valid && upd_ready && sel == 3'd7)
      lock_cnt <= LW'(HEAL_LOCKOUT_S);
    else if (sec_tick && lock_cnt != '0)
      lock_cnt <= lock_cnt - LW'(1);
  end

  assign heal_ok = (lock_cnt == '0);
`else
  assign heal_ok = 1'b1;
`endif

  assign set_req = {act_heal & heal_ok, act_feed, act_rest, act_play, expire};
  assign clr     = (upd_valid && upd_ready) ? (8'b1 << sel) : 8'b0;

  // A new request wins over a same-cycle clear; only a truly lost request flags drop_err.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pend     <= '0;
      drop_err <= 1'b0;
    end else begin
      pend <= (pend & ~clr) | set_req;
      if (|(set_req & pend & ~clr)) drop_err <= 1'b1;
    end
  end

  always_comb begin
    win   = '0;
    cand  = '0;
    found = 1'b0;
    if (pend[7])      win = 3'd7;
    else if (pend[6]) win = 3'd6;
    else if (pend[5]) win = 3'd5;
    else if (pend[4]) win = 3'd4;
    else begin
      for (int i = 1; i <= 4; i++) begin
        cand = last + 2'(i);
        if (!found && pend[cand]) begin
          win   = {1'b0, cand};
          found = 1'b1;
        end
      end
    end
  end

  // Round-robin pointer resets to happy so the first decay search begins at food.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      upd_valid <= 1'b0;
      upd_stat  <= '0;
      upd_up    <= 1'b0;
      sel       <= '0;
      last      <= 2'd3;
    end else begin
      case (state)
        IDLE: begin
          if (|pend) begin
            {upd_stat, upd_up} <= cmd_of(win);
            sel       <= win;
            upd_valid <= 1'b1;
            state     <= OFFER;
            if (!win[2]) last <= win[1:0];
          end
        end
        OFFER: begin
          if (upd_ready) begin
            upd_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
